// File: rtl/cfg_port_arbiter.sv
// Round-robin arbiter sharing the configurator port between NR requesters, with busy-gated regions and routed read data.
// Optional build macro CFG_ARB_LOCK_EN adds req_lock for atomic sequences by a single requester.
module cfg_port_arbiter #(
    parameter int NR  = 2,
    parameter int CDW = 21,
    parameter int CAW = 15,
    parameter int ATW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NR-1:0]     req_valid,
    input  logic [NR-1:0]     req_we,
    input  logic [NR*CAW-1:0] req_addr,
    input  logic [NR*CDW-1:0] req_wdata,
`ifdef CFG_ARB_LOCK_EN
    input  logic [NR-1:0]     req_lock,
`endif
    output logic [NR-1:0]     req_ready,
    output logic [NR-1:0]     rsp_valid,
    output logic [CDW-1:0]    rsp_rdata,
    input  logic              axon_busy,
    input  logic              work_config_busy,
    output logic              config_we,
    output logic [CAW-1:0]    config_waddr,
    output logic [CDW-1:0]    config_wdata,
    output logic              config_re,
    output logic [CAW-1:0]    config_raddr,
    input  logic [CDW-1:0]    config_rdata
);

    localparam int          PW  = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned NRU = NR;

    localparam logic [ATW-1:0] T_WEIGHT = ATW'(1);
    localparam logic [ATW-1:0] T_DEST   = ATW'(2);
    localparam logic [ATW-1:0] T_VMMEM  = ATW'(4);
    localparam logic [ATW-1:0] T_VMBUF  = ATW'(6);

    logic [NR-1:0]  elig;
    logic [NR-1:0]  locked_out;
    logic [PW-1:0]  win;
    logic           found;
    logic           accept;
    logic           sel_we;
    logic           sel_lock;
    logic [CAW-1:0] sel_addr;
    logic [CDW-1:0] sel_wdata;
    logic           lock_active;

    logic [PW-1:0]  ptr_q, ptr_d;
    logic           we_q, re_q;
    logic [CAW-1:0] waddr_q, raddr_q;
    logic [CDW-1:0] wdata_q;
    logic           tag1_v_q, tag2_v_q;
    logic [PW-1:0]  tag1_id_q, tag2_id_q;
    logic [NR-1:0]  rsp_valid_q, rsp_valid_d;
    logic [CDW-1:0] rsp_rdata_q;

    // Region availability from the address type field.
    always_comb begin
        logic [ATW-1:0] typ;
        logic           free;
        elig = '0;
        for (int unsigned i = 0; i < NRU; i++) begin
            typ  = req_addr[i*CAW + CAW - ATW +: ATW];
            free = 1'b1;
            if (typ == T_WEIGHT || typ == T_VMBUF)
                free = !axon_busy;
            else if (typ == T_DEST || typ == T_VMMEM)
                free = !work_config_busy;
            elig[i] = req_valid[i] && free && !locked_out[i];
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 1; k <= NRU; k++) begin
            idx = PW'((32'(ptr_q) + k) % NRU);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NRU; i++) begin
            req_ready[i] = rst_n && found && (win == PW'(i));
            if (req_ready[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*CAW +: CAW];
                sel_wdata = req_wdata[i*CDW +: CDW];
`ifdef CFG_ARB_LOCK_EN
                sel_lock  = req_lock[i];
`endif
            end
        end
    end

    assign accept = |req_ready;

`ifdef CFG_ARB_LOCK_EN
    logic          lock_held_q, lock_held_d;
    logic [PW-1:0] lock_owner_q, lock_owner_d;

    assign lock_active = lock_held_q;

    always_comb begin
        locked_out = '0;
        for (int unsigned i = 0; i < NRU; i++)
            locked_out[i] = lock_held_q && (lock_owner_q != PW'(i));
    end

    // Owner releases by an unlocked accept or by going idle with lock low.
    always_comb begin
        lock_held_d  = lock_held_q;
        lock_owner_d = lock_owner_q;
        for (int unsigned i = 0; i < NRU; i++) begin
            if (lock_held_q && lock_owner_q == PW'(i) && !req_lock[i] &&
                (req_ready[i] || !req_valid[i]))
                lock_held_d = 1'b0;
        end
        if (accept && sel_lock) begin
            lock_held_d  = 1'b1;
            lock_owner_d = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_held_q  <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_held_q  <= lock_held_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    assign lock_active = 1'b0;
    assign locked_out  = '0;
`endif

    always_comb begin
        ptr_d = ptr_q;
        if (accept && !lock_active)
            ptr_d = win;
    end

    always_comb begin
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < NRU; i++)
            rsp_valid_d[i] = tag2_v_q && (tag2_id_q == PW'(i));
    end

    // Stage 1 lines up with config_re, stage 2 with config_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= PW'(NR - 1);
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            tag1_v_q    <= 1'b0;
            tag1_id_q   <= '0;
            tag2_v_q    <= 1'b0;
            tag2_id_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            we_q     <= accept && sel_we;
            re_q     <= accept && !sel_we;
            tag1_v_q <= accept && !sel_we;
            if (accept)
                tag1_id_q <= win;
            if (accept && sel_we) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (accept && !sel_we)
                raddr_q <= sel_addr;
            tag2_v_q    <= tag1_v_q;
            tag2_id_q   <= tag1_id_q;
            rsp_valid_q <= rsp_valid_d;
            if (tag2_v_q)
                rsp_rdata_q <= config_rdata;
        end
    end

    assign config_we    = we_q;
    assign config_waddr = waddr_q;
    assign config_wdata = wdata_q;
    assign config_re    = re_q;
    assign config_raddr = raddr_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;

endmodule

// File: tb/tb_cfg_port_arbiter.sv
// Directed bench for cfg_port_arbiter (NR=2); the lock sequence runs only when CFG_ARB_LOCK_EN is defined.
module tb_cfg_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [29:0] req_addr;
    logic [41:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [20:0] rsp_rdata;
    logic        axon_busy;
    logic        work_config_busy;
    logic        config_we;
    logic [14:0] config_waddr;
    logic [20:0] config_wdata;
    logic        config_re;
    logic [14:0] config_raddr;
    logic [20:0] config_rdata;
`ifdef CFG_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cfg_port_arbiter #(.NR(2), .CDW(21), .CAW(15), .ATW(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
`ifdef CFG_ARB_LOCK_EN
        .req_lock         (req_lock),
`endif
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .axon_busy        (axon_busy),
        .work_config_busy (work_config_busy),
        .config_we        (config_we),
        .config_waddr     (config_waddr),
        .config_wdata     (config_wdata),
        .config_re        (config_re),
        .config_raddr     (config_raddr),
        .config_rdata     (config_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [1:0] w,
                           input logic [14:0] a0, input logic [14:0] a1,
                           input logic [20:0] d0, input logic [20:0] d1);
        req_valid = v;
        req_we    = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        axon_busy = 1'b0;
        work_config_busy = 1'b0;
        config_rdata = '0;
`ifdef CFG_ARB_LOCK_EN
        req_lock = '0;
`endif
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        tick();
        // Reset state, with a request pending that must not be accepted
        set_req(2'b01, 2'b01, 15'h0005, 15'h0, 21'h1, 21'h0);
        mid();
        chk("rst_ready", 32'(req_ready), 'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 'h0);
        chk("rst_we", 32'(config_we), 'h0);
        chk("rst_re", 32'(config_re), 'h0);
        chk("rst_waddr", 32'(config_waddr), 'h0);
        chk("rst_wdata", 32'(config_wdata), 'h0);
        chk("rst_raddr", 32'(config_raddr), 'h0);
        tick();

        // Fairness: both write continuously, requester 0 first
        rst_n = 1'b1;
        set_req(2'b11, 2'b11, 15'h0010, 15'h0020, 21'h100, 21'h200);
        mid(); chk("fair_g0", 32'(req_ready), 'h1); tick();
        mid(); chk("fair_g1", 32'(req_ready), 'h2);
        chk("fair_we1", 32'(config_we), 'h1);
        chk("fair_waddr1", 32'(config_waddr), 'h10);
        chk("fair_wdata1", 32'(config_wdata), 'h100); tick();
        mid(); chk("fair_g2", 32'(req_ready), 'h1);
        chk("fair_waddr2", 32'(config_waddr), 'h20);
        chk("fair_wdata2", 32'(config_wdata), 'h200); tick();
        mid(); chk("fair_g3", 32'(req_ready), 'h2);
        chk("fair_waddr3", 32'(config_waddr), 'h10); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        mid(); chk("fair_idle_ready", 32'(req_ready), 'h0);
        chk("fair_we4", 32'(config_we), 'h1);
        chk("fair_waddr4", 32'(config_waddr), 'h20); tick();
        mid(); chk("fair_we_pulse", 32'(config_we), 'h0); tick();

        // Single write
        set_req(2'b01, 2'b01, 15'h0005, 15'h0, 21'h1ABCD, 21'h0);
        mid(); chk("wr_ready", 32'(req_ready), 'h1); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        mid(); chk("wr_we", 32'(config_we), 'h1);
        chk("wr_waddr", 32'(config_waddr), 'h5);
        chk("wr_wdata", 32'(config_wdata), 'h1ABCD);
        chk("wr_re", 32'(config_re), 'h0); tick();
        mid(); chk("wr_we_off", 32'(config_we), 'h0);
        chk("wr_waddr_hold", 32'(config_waddr), 'h5); tick();

        // Busy gating: weight write blocked while axon_busy, read served meanwhile
        axon_busy = 1'b1;
        set_req(2'b11, 2'b01, 15'h1003, 15'h0002, 21'h33, 21'h0);
        mid(); chk("busy_r1_first", 32'(req_ready), 'h2); tick();
        set_req(2'b01, 2'b01, 15'h1003, 15'h0002, 21'h33, 21'h0);
        mid(); chk("busy_blocked", 32'(req_ready), 'h0);
        chk("busy_re", 32'(config_re), 'h1);
        chk("busy_raddr", 32'(config_raddr), 'h2);
        chk("busy_we_none", 32'(config_we), 'h0); tick();
        axon_busy = 1'b0;
        config_rdata = 21'h0002A;
        mid(); chk("busy_release", 32'(req_ready), 'h1);
        chk("busy_re_pulse", 32'(config_re), 'h0); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        mid(); chk("busy_we", 32'(config_we), 'h1);
        chk("busy_waddr", 32'(config_waddr), 'h1003);
        chk("busy_wdata", 32'(config_wdata), 'h33);
        chk("busy_rsp_valid", 32'(rsp_valid), 'h2);
        chk("busy_rsp_rdata", 32'(rsp_rdata), 'h2A); tick();
        work_config_busy = 1'b1;
        set_req(2'b01, 2'b01, 15'h2004, 15'h0, 21'h44, 21'h0);
        mid(); chk("wcb_blocked", 32'(req_ready), 'h0);
        chk("busy_rsp_pulse", 32'(rsp_valid), 'h0);
        chk("busy_rdata_hold", 32'(rsp_rdata), 'h2A); tick();
        work_config_busy = 1'b0;
        axon_busy = 1'b1;
        mid(); chk("wcb_release", 32'(req_ready), 'h1); tick();
        axon_busy = 1'b0;
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        mid(); chk("wcb_waddr", 32'(config_waddr), 'h2004);
        chk("wcb_wdata", 32'(config_wdata), 'h44); tick();

        // Back-to-back reads: requester 1 then requester 0
        set_req(2'b10, 2'b00, 15'h0, 15'h0001, 21'h0, 21'h0);
        mid(); chk("rd_g1", 32'(req_ready), 'h2); tick();
        set_req(2'b01, 2'b00, 15'h4002, 15'h0, 21'h0, 21'h0);
        mid(); chk("rd_g0", 32'(req_ready), 'h1);
        chk("rd_re1", 32'(config_re), 'h1);
        chk("rd_raddr1", 32'(config_raddr), 'h1); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        config_rdata = 21'h00011;
        mid(); chk("rd_re2", 32'(config_re), 'h1);
        chk("rd_raddr2", 32'(config_raddr), 'h4002);
        chk("rd_no_rsp_early", 32'(rsp_valid), 'h0); tick();
        config_rdata = 21'h00022;
        mid(); chk("rd_rsp1_valid", 32'(rsp_valid), 'h2);
        chk("rd_rsp1_data", 32'(rsp_rdata), 'h11);
        chk("rd_re_off", 32'(config_re), 'h0); tick();
        config_rdata = 21'h1FFFF;
        mid(); chk("rd_rsp0_valid", 32'(rsp_valid), 'h1);
        chk("rd_rsp0_data", 32'(rsp_rdata), 'h22); tick();
        mid(); chk("rd_rsp_done", 32'(rsp_valid), 'h0);
        chk("rd_rdata_hold", 32'(rsp_rdata), 'h22); tick();

        // Write then read of the same address stay in order
        set_req(2'b01, 2'b01, 15'h0030, 15'h0, 21'h155, 21'h0);
        mid(); chk("raw_wr_ready", 32'(req_ready), 'h1); tick();
        set_req(2'b01, 2'b00, 15'h0030, 15'h0, 21'h0, 21'h0);
        mid(); chk("raw_rd_ready", 32'(req_ready), 'h1);
        chk("raw_we", 32'(config_we), 'h1);
        chk("raw_re_not_yet", 32'(config_re), 'h0); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        mid(); chk("raw_re", 32'(config_re), 'h1);
        chk("raw_raddr", 32'(config_raddr), 'h30);
        chk("raw_we_off", 32'(config_we), 'h0); tick();
        config_rdata = 21'h00155;
        mid(); chk("raw_no_rsp", 32'(rsp_valid), 'h0); tick();
        mid(); chk("raw_rsp_valid", 32'(rsp_valid), 'h1);
        chk("raw_rsp_data", 32'(rsp_rdata), 'h155); tick();

        // Reset one cycle after a read accept discards it
        set_req(2'b10, 2'b00, 15'h0, 15'h0020, 21'h0, 21'h0);
        mid(); chk("mr_ready", 32'(req_ready), 'h2); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        rst_n = 1'b0;
        mid(); chk("mr_re", 32'(config_re), 'h0);
        chk("mr_ready0", 32'(req_ready), 'h0);
        chk("mr_raddr", 32'(config_raddr), 'h0);
        chk("mr_waddr", 32'(config_waddr), 'h0);
        chk("mr_wdata", 32'(config_wdata), 'h0);
        chk("mr_rdata", 32'(rsp_rdata), 'h0); tick();
        config_rdata = 21'h0003C;
        mid(); chk("mr_rsp_a", 32'(rsp_valid), 'h0); tick();
        rst_n = 1'b1;
        mid(); chk("mr_rsp_b", 32'(rsp_valid), 'h0); tick();
        mid(); chk("mr_rsp_c", 32'(rsp_valid), 'h0);
        chk("mr_rdata_c", 32'(rsp_rdata), 'h0); tick();
        set_req(2'b11, 2'b11, 15'h0050, 15'h0060, 21'h1, 21'h2);
        mid(); chk("mr_prio0", 32'(req_ready), 'h1); tick();
        set_req(2'b10, 2'b10, 15'h0, 15'h0060, 21'h0, 21'h2);
        mid(); chk("mr_g1", 32'(req_ready), 'h2);
        chk("mr_waddr_post", 32'(config_waddr), 'h50);
        chk("mr_rsp_d", 32'(rsp_valid), 'h0); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        mid(); chk("mr_waddr_post1", 32'(config_waddr), 'h60); tick();

`ifdef CFG_ARB_LOCK_EN
        // Locked read then unlocked write by requester 0 while requester 1 waits
        req_lock = 2'b01;
        set_req(2'b11, 2'b10, 15'h0001, 15'h0040, 21'h0, 21'h77);
        mid(); chk("lk_g0_read", 32'(req_ready), 'h1); tick();
        req_lock = 2'b00;
        set_req(2'b11, 2'b11, 15'h0001, 15'h0040, 21'h12, 21'h77);
        mid(); chk("lk_g0_write", 32'(req_ready), 'h1);
        chk("lk_re", 32'(config_re), 'h1); tick();
        set_req(2'b10, 2'b10, 15'h0, 15'h0040, 21'h0, 21'h77);
        config_rdata = 21'h0005A;
        mid(); chk("lk_g1", 32'(req_ready), 'h2);
        chk("lk_waddr", 32'(config_waddr), 'h1);
        chk("lk_wdata", 32'(config_wdata), 'h12); tick();
        set_req(2'b00, 2'b00, 15'h0, 15'h0, 21'h0, 21'h0);
        mid(); chk("lk_waddr1", 32'(config_waddr), 'h40);
        chk("lk_rsp_valid", 32'(rsp_valid), 'h1);
        chk("lk_rsp_data", 32'(rsp_rdata), 'h5A); tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
